// File: rtl/pos_input_ring_node_ext.sv
// Purpose : ring node that forwards offset packets, copies the remotely consumed share of
//           a packet's lifetime to a remote FPGA, and injects queued remote packets into free ring slots.
// Latency : 1 cycle for every output except o_node_empty, which is combinational from the FIFO count.
// Backpres: remote egress back-pressure leaves the ring packet unchanged so a downstream node can retry;
//           remote ingress is acked only when the FIFO is not full at the start of the cycle.
//
// Ports:
//   clk, rst                                   clock, async active-low reset
//   i_source_*                                 ring packet from the previous node (valid when lifetime != 0)
//   i_remote_*                                 packet arriving from the remote FPGA
//   i_remote_buffer_back_pressure              remote egress cannot accept
//   o_*_to_ring                                ring packet to the next node
//   o_*_to_remote                              packet copy to the remote FPGA
//   o_remote_ack                               one-cycle pulse per accepted remote packet
//   o_node_empty                               remote-ingress FIFO empty
module pos_input_ring_node_ext #(
    parameter int OFFSET_PKT_STRUCT_WIDTH = 79,
    parameter int GLOBAL_CELL_ID_WIDTH    = 3,
    parameter int NB_CELL_COUNT_WIDTH     = 5,
    parameter int RFIFO_DEPTH             = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [OFFSET_PKT_STRUCT_WIDTH-1:0]  i_source_offset_pkt,
    input  logic [3*GLOBAL_CELL_ID_WIDTH-1:0]   i_source_gcid,
    input  logic [NB_CELL_COUNT_WIDTH-1:0]      i_source_lifetime,
    input  logic [NB_CELL_COUNT_WIDTH-1:0]      i_source_lifetime_split_remote,
    input  logic [OFFSET_PKT_STRUCT_WIDTH-1:0]  i_remote_offset_pkt,
    input  logic [3*GLOBAL_CELL_ID_WIDTH-1:0]   i_remote_gcid,
    input  logic                                i_remote_valid,
    input  logic [NB_CELL_COUNT_WIDTH-1:0]      i_remote_lifetime,
    input  logic                                i_remote_buffer_back_pressure,
    output logic [OFFSET_PKT_STRUCT_WIDTH-1:0]  o_offset_pkt_to_ring,
    output logic [3*GLOBAL_CELL_ID_WIDTH-1:0]   o_gcid_to_ring,
    output logic [NB_CELL_COUNT_WIDTH-1:0]      o_lifetime_to_ring,
    output logic [NB_CELL_COUNT_WIDTH-1:0]      o_lifetime_split_remote_to_ring,
    output logic [OFFSET_PKT_STRUCT_WIDTH-1:0]  o_offset_pkt_to_remote,
    output logic [3*GLOBAL_CELL_ID_WIDTH-1:0]   o_gcid_to_remote,
    output logic                                o_offset_pkt_to_remote_valid,
    output logic [NB_CELL_COUNT_WIDTH-1:0]      o_lifetime_to_remote,
    output logic                                o_remote_ack,
    output logic                                o_node_empty
);

    localparam int PW = OFFSET_PKT_STRUCT_WIDTH;
    localparam int GW = 3 * GLOBAL_CELL_ID_WIDTH;
    localparam int LW = NB_CELL_COUNT_WIDTH;
    localparam int AW = (RFIFO_DEPTH > 1) ? $clog2(RFIFO_DEPTH) : 1;
    localparam int CW = $clog2(RFIFO_DEPTH + 1);

    typedef struct packed {
        logic [PW-1:0] pkt;
        logic [GW-1:0] gcid;
        logic [LW-1:0] lt;
    } entry_t;

    // ---------------- remote-ingress FIFO ----------------
    entry_t          mem_q [RFIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            fifo_full, fifo_empty;
    logic            accept, push, pop;
    entry_t          head;

    assign fifo_full  = (cnt_q == CW'(RFIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign head       = mem_q[rd_ptr_q];

    // Fullness is judged on the registered count, so a pop in the same cycle never frees a slot for accept.
    assign accept = i_remote_valid && !fifo_full;
    // Zero-lifetime packets are acked but never stored.
    assign push   = accept && (i_remote_lifetime != '0);

    // ---------------- source split / slot arbitration ----------------
    logic [LW-1:0]   split_c;
    logic            src_vld, to_remote, slot_free;
    logic [LW-1:0]   ring_lt_after;

    logic [PW-1:0]   ring_pkt_q, ring_pkt_d;
    logic [GW-1:0]   ring_gcid_q, ring_gcid_d;
    logic [LW-1:0]   ring_lt_q, ring_lt_d;
    logic [LW-1:0]   ring_split_q, ring_split_d;
    logic [PW-1:0]   rem_pkt_q, rem_pkt_d;
    logic [GW-1:0]   rem_gcid_q, rem_gcid_d;
    logic            rem_vld_q, rem_vld_d;
    logic [LW-1:0]   rem_lt_q, rem_lt_d;
    logic            ack_q;

    always_comb begin
        src_vld       = (i_source_lifetime != '0);
        // Clamp so the ring lifetime can never underflow.
        split_c       = (i_source_lifetime_split_remote > i_source_lifetime) ?
                        i_source_lifetime : i_source_lifetime_split_remote;
        to_remote     = src_vld && (split_c != '0) && !i_remote_buffer_back_pressure;
        ring_lt_after = i_source_lifetime - split_c;

        // Default: ring passes the source through unchanged (covers split=0 and back-pressure).
        ring_pkt_d   = i_source_offset_pkt;
        ring_gcid_d  = i_source_gcid;
        ring_lt_d    = i_source_lifetime;
        ring_split_d = i_source_lifetime_split_remote;
        rem_pkt_d    = '0;
        rem_gcid_d   = '0;
        rem_vld_d    = 1'b0;
        rem_lt_d     = '0;
        pop          = 1'b0;

        if (to_remote) begin
            rem_pkt_d    = i_source_offset_pkt;
            rem_gcid_d   = i_source_gcid;
            rem_vld_d    = 1'b1;
            rem_lt_d     = split_c;
            ring_lt_d    = ring_lt_after;
            ring_split_d = '0;
        end

        slot_free = !src_vld || (to_remote && (ring_lt_after == '0));

        if (slot_free) begin
            if (!fifo_empty) begin
                pop          = 1'b1;
                ring_pkt_d   = head.pkt;
                ring_gcid_d  = head.gcid;
                ring_lt_d    = head.lt;
                ring_split_d = '0;
            end else begin
                ring_pkt_d   = '0;
                ring_gcid_d  = '0;
                ring_lt_d    = '0;
                ring_split_d = '0;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == AW'(RFIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(RFIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Storage needs no reset: the pointers/count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{pkt: i_remote_offset_pkt, gcid: i_remote_gcid, lt: i_remote_lifetime};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            ring_pkt_q   <= '0;
            ring_gcid_q  <= '0;
            ring_lt_q    <= '0;
            ring_split_q <= '0;
            rem_pkt_q    <= '0;
            rem_gcid_q   <= '0;
            rem_vld_q    <= 1'b0;
            rem_lt_q     <= '0;
            ack_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            ring_pkt_q   <= ring_pkt_d;
            ring_gcid_q  <= ring_gcid_d;
            ring_lt_q    <= ring_lt_d;
            ring_split_q <= ring_split_d;
            rem_pkt_q    <= rem_pkt_d;
            rem_gcid_q   <= rem_gcid_d;
            rem_vld_q    <= rem_vld_d;
            rem_lt_q     <= rem_lt_d;
            ack_q        <= accept;
        end
    end

    assign o_offset_pkt_to_ring            = ring_pkt_q;
    assign o_gcid_to_ring                  = ring_gcid_q;
    assign o_lifetime_to_ring              = ring_lt_q;
    assign o_lifetime_split_remote_to_ring = ring_split_q;
    assign o_offset_pkt_to_remote          = rem_pkt_q;
    assign o_gcid_to_remote                = rem_gcid_q;
    assign o_offset_pkt_to_remote_valid    = rem_vld_q;
    assign o_lifetime_to_remote            = rem_lt_q;
    assign o_remote_ack                    = ack_q;
    assign o_node_empty                    = fifo_empty;

endmodule

// File: tb/tb_pos_input_ring_node_ext.sv
// Purpose : directed self-checking bench for pos_input_ring_node_ext.
// Latency : outputs are sampled 1 time unit after the rising edge that registers them.
// Backpres: exercises remote egress back-pressure and remote-ingress FIFO full.
module tb_pos_input_ring_node_ext;

    logic        clk = 1'b0;
    logic        rst;
    logic [78:0] src_pkt;
    logic [8:0]  src_gcid;
    logic [4:0]  src_lt, src_split;
    logic [78:0] rem_pkt;
    logic [8:0]  rem_gcid;
    logic        rem_vld;
    logic [4:0]  rem_lt;
    logic        bp;
    logic [78:0] o_ring_pkt, o_rem_pkt;
    logic [8:0]  o_ring_gcid, o_rem_gcid;
    logic [4:0]  o_ring_lt, o_ring_split, o_rem_lt;
    logic        o_rem_vld, o_ack, o_empty;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pos_input_ring_node_ext dut (
        .clk                             (clk),
        .rst                             (rst),
        .i_source_offset_pkt             (src_pkt),
        .i_source_gcid                   (src_gcid),
        .i_source_lifetime               (src_lt),
        .i_source_lifetime_split_remote  (src_split),
        .i_remote_offset_pkt             (rem_pkt),
        .i_remote_gcid                   (rem_gcid),
        .i_remote_valid                  (rem_vld),
        .i_remote_lifetime               (rem_lt),
        .i_remote_buffer_back_pressure   (bp),
        .o_offset_pkt_to_ring            (o_ring_pkt),
        .o_gcid_to_ring                  (o_ring_gcid),
        .o_lifetime_to_ring              (o_ring_lt),
        .o_lifetime_split_remote_to_ring (o_ring_split),
        .o_offset_pkt_to_remote          (o_rem_pkt),
        .o_gcid_to_remote                (o_rem_gcid),
        .o_offset_pkt_to_remote_valid    (o_rem_vld),
        .o_lifetime_to_remote            (o_rem_lt),
        .o_remote_ack                    (o_ack),
        .o_node_empty                    (o_empty)
    );

    function automatic logic [78:0] mk_pkt(input logic [7:0] id);
        return {id, 2'd1, 23'(id), 23'(id) + 23'd1, 23'd7};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input logic [7:0] id, input logic [8:0] g, input logic [4:0] lt, input logic [4:0] sp);
        src_pkt = mk_pkt(id); src_gcid = g; src_lt = lt; src_split = sp;
    endtask

    task automatic set_rem(input logic v, input logic [7:0] id, input logic [8:0] g, input logic [4:0] lt);
        rem_vld = v; rem_pkt = mk_pkt(id); rem_gcid = g; rem_lt = lt;
    endtask

    initial begin
        rst = 1'b0; bp = 1'b0;
        set_src(8'd0, 9'd0, 5'd0, 5'd0);
        set_rem(1'b0, 8'd0, 9'd0, 5'd0);
        #3;
        chk("rst_ring_lt", 128'(o_ring_lt), 128'd0);
        chk("rst_ring_pkt", 128'(o_ring_pkt), 128'd0);
        chk("rst_rem_vld", 128'(o_rem_vld), 128'd0);
        chk("rst_ack", 128'(o_ack), 128'd0);
        chk("rst_empty", 128'(o_empty), 128'd1);
        tick();
        rst = 1'b1;

        // Remote id1 lt4 with idle source: ack, then injection next cycle.
        set_rem(1'b1, 8'd1, 9'd0, 5'd4);
        tick();
        chk("r1_ack", 128'(o_ack), 128'd1);
        chk("r1_empty0", 128'(o_empty), 128'd0);
        chk("r1_ring_idle", 128'(o_ring_lt), 128'd0);
        set_rem(1'b0, 8'd0, 9'd0, 5'd0);
        tick();
        chk("r1_ack_off", 128'(o_ack), 128'd0);
        chk("r1_ring_pkt", 128'(o_ring_pkt), 128'(mk_pkt(8'd1)));
        chk("r1_ring_lt", 128'(o_ring_lt), 128'd4);
        chk("r1_ring_split", 128'(o_ring_split), 128'd0);
        chk("r1_empty1", 128'(o_empty), 128'd1);

        // Remote id2 lt0: acked and discarded.
        set_rem(1'b1, 8'd2, 9'd0, 5'd0);
        tick();
        chk("r2_ack", 128'(o_ack), 128'd1);
        chk("r2_empty", 128'(o_empty), 128'd1);
        set_rem(1'b0, 8'd0, 9'd0, 5'd0);
        tick();
        chk("r2_no_inject", 128'(o_ring_lt), 128'd0);

        // Source id4 lt8 split3, no back-pressure, remote id3 lt3 in the same cycle.
        set_src(8'd4, 9'h1FF, 5'd8, 5'd3);
        set_rem(1'b1, 8'd3, 9'd5, 5'd3);
        tick();
        chk("s4_ring_pkt", 128'(o_ring_pkt), 128'(mk_pkt(8'd4)));
        chk("s4_ring_gcid", 128'(o_ring_gcid), 128'h1FF);
        chk("s4_ring_lt", 128'(o_ring_lt), 128'd5);
        chk("s4_ring_split", 128'(o_ring_split), 128'd0);
        chk("s4_rem_vld", 128'(o_rem_vld), 128'd1);
        chk("s4_rem_pkt", 128'(o_rem_pkt), 128'(mk_pkt(8'd4)));
        chk("s4_rem_gcid", 128'(o_rem_gcid), 128'h1FF);
        chk("s4_rem_lt", 128'(o_rem_lt), 128'd3);
        chk("s4_ack", 128'(o_ack), 128'd1);
        set_src(8'd0, 9'd0, 5'd0, 5'd0);
        set_rem(1'b0, 8'd0, 9'd0, 5'd0);
        tick();
        chk("r3_ring_pkt", 128'(o_ring_pkt), 128'(mk_pkt(8'd3)));
        chk("r3_ring_gcid", 128'(o_ring_gcid), 128'd5);
        chk("r3_ring_lt", 128'(o_ring_lt), 128'd3);
        chk("r3_rem_vld", 128'(o_rem_vld), 128'd0);

        // Same source under back-pressure: passes unchanged.
        set_src(8'd4, 9'h1FF, 5'd8, 5'd3);
        bp = 1'b1;
        tick();
        chk("bp_ring_lt", 128'(o_ring_lt), 128'd8);
        chk("bp_ring_split", 128'(o_ring_split), 128'd3);
        chk("bp_rem_vld", 128'(o_rem_vld), 128'd0);
        bp = 1'b0;

        // Queue id5 with idle source, then source fully consumed remotely frees the slot.
        set_src(8'd0, 9'd0, 5'd0, 5'd0);
        set_rem(1'b1, 8'd5, 9'd2, 5'd2);
        tick();
        chk("q5_ring_empty", 128'(o_ring_lt), 128'd0);
        set_rem(1'b0, 8'd0, 9'd0, 5'd0);
        set_src(8'd6, 9'd9, 5'd3, 5'd3);
        tick();
        chk("s6_rem_vld", 128'(o_rem_vld), 128'd1);
        chk("s6_rem_pkt", 128'(o_rem_pkt), 128'(mk_pkt(8'd6)));
        chk("s6_rem_lt", 128'(o_rem_lt), 128'd3);
        chk("s6_ring_pkt", 128'(o_ring_pkt), 128'(mk_pkt(8'd5)));
        chk("s6_ring_lt", 128'(o_ring_lt), 128'd2);
        chk("s6_empty", 128'(o_empty), 128'd1);

        // Split larger than lifetime is clamped.
        set_src(8'd7, 9'd1, 5'd2, 5'd5);
        tick();
        chk("clamp_rem_lt", 128'(o_rem_lt), 128'd2);
        chk("clamp_ring_lt", 128'(o_ring_lt), 128'd0);

        // Split zero: pass-through, no remote copy.
        set_src(8'd8, 9'd3, 5'd6, 5'd0);
        tick();
        chk("sp0_ring_pkt", 128'(o_ring_pkt), 128'(mk_pkt(8'd8)));
        chk("sp0_ring_lt", 128'(o_ring_lt), 128'd6);
        chk("sp0_rem_vld", 128'(o_rem_vld), 128'd0);

        // Hold remote valid against a busy ring: exactly four acks.
        set_src(8'h20, 9'd0, 5'd5, 5'd0);
        for (int i = 0; i < 6; i++) begin
            set_rem(1'b1, 8'(8'h10 + i), 9'd0, 5'd1);
            tick();
            chk($sformatf("fill_ack%0d", i), 128'(o_ack), (i < 4) ? 128'd1 : 128'd0);
        end
        chk("fill_ring_lt", 128'(o_ring_lt), 128'd5);
        // Free the slot: pop while full does not allow accept.
        set_src(8'd0, 9'd0, 5'd0, 5'd0);
        set_rem(1'b1, 8'h16, 9'd0, 5'd1);
        tick();
        chk("full_pop_ack", 128'(o_ack), 128'd0);
        chk("full_pop_pkt", 128'(o_ring_pkt), 128'(mk_pkt(8'h10)));
        // Now not full: push and pop together.
        set_rem(1'b1, 8'h17, 9'd0, 5'd1);
        tick();
        chk("pp_ack", 128'(o_ack), 128'd1);
        chk("pp_ring_pkt", 128'(o_ring_pkt), 128'(mk_pkt(8'h11)));
        chk("pp_empty", 128'(o_empty), 128'd0);

        // Reset mid-stream clears outputs immediately.
        rst = 1'b0;
        #1;
        chk("mrst_ring_lt", 128'(o_ring_lt), 128'd0);
        chk("mrst_ring_pkt", 128'(o_ring_pkt), 128'd0);
        chk("mrst_ack", 128'(o_ack), 128'd0);
        chk("mrst_empty", 128'(o_empty), 128'd1);
        set_rem(1'b0, 8'd0, 9'd0, 5'd0);
        #2;
        rst = 1'b1;
        tick();
        chk("post_rst_ring", 128'(o_ring_lt), 128'd0);
        chk("post_rst_empty", 128'(o_empty), 128'd1);
        set_src(8'd9, 9'd4, 5'd4, 5'd0);
        tick();
        chk("post_rst_pkt", 128'(o_ring_pkt), 128'(mk_pkt(8'd9)));
        chk("post_rst_lt", 128'(o_ring_lt), 128'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pos_input_ring_node_ext.md
POS_INPUT_RING_NODE_EXT -- requirements
Module: pos_input_ring_node_ext

Interface
REQ-001 SHALL have parameter OFFSET_PKT_STRUCT_WIDTH, default 79: offset packet width, {particle_id[8], element[2], z/y/x offsets[3x23]}, x at LSBs.
REQ-002 SHALL have parameter GLOBAL_CELL_ID_WIDTH, default 3: per-axis cell id width; gcid ports are 3x this width.
REQ-003 SHALL have parameter NB_CELL_COUNT_WIDTH, default 5: lifetime width (remaining neighbour-cell visits).
REQ-004 SHALL have parameter RFIFO_DEPTH, default 4: remote-ingress FIFO depth (power of 2).
REQ-005 clk  in  1  single clock; all state on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 i_source_offset_pkt / i_source_gcid / i_source_lifetime / i_source_lifetime_split_remote  in  OFFSET_PKT / 3xGCID / NBC / NBC  ring packet from previous node; valid when lifetime != 0; split = portion of lifetime to be consumed remotely.
REQ-008 i_remote_offset_pkt / i_remote_gcid / i_remote_valid / i_remote_lifetime  in  OFFSET_PKT / 3xGCID / 1 / NBC  packet from remote FPGA.
REQ-009 i_remote_buffer_back_pressure  in  1  remote egress cannot accept.
REQ-010 o_offset_pkt_to_ring / o_gcid_to_ring / o_lifetime_to_ring / o_lifetime_split_remote_to_ring  out  ring output to next node; valid when lifetime != 0.
REQ-011 o_offset_pkt_to_remote / o_gcid_to_remote / o_offset_pkt_to_remote_valid / o_lifetime_to_remote  out  packet copy to remote FPGA.
REQ-012 o_remote_ack  out  1  one-cycle pulse per accepted remote packet.
REQ-013 o_node_empty  out  1  remote-ingress FIFO empty.

Function
REQ-014 All outputs except o_node_empty SHALL be registered, 1-cycle latency from inputs.
REQ-015 Source valid, split != 0, back_pressure=0: remote output = source pkt/gcid, valid=1, lifetime_to_remote=split; ring output = source pkt/gcid, lifetime=source_lifetime-split, split_to_ring=0.
REQ-016 Source valid, split != 0, back_pressure=1: remote valid=0; ring output = source unchanged (lifetime and split kept) for a downstream node to retry.
REQ-017 Source valid, split=0: ring output = source unchanged; remote valid=0.
REQ-018 Split > source_lifetime SHALL be clamped to source_lifetime (no underflow).
REQ-019 Ring slot is free when source lifetime=0 or REQ-015 yields ring lifetime 0; then, if FIFO non-empty, head SHALL be popped onto ring with its lifetime, split_to_ring=0.
REQ-020 Free slot, FIFO empty: ring output pkt/gcid=0, lifetime=0, split=0.
REQ-021 Remote packets SHALL never bypass the FIFO; a packet written at edge N is injectable at earliest at edge N+1.
REQ-022 i_remote_valid=1 and FIFO not full at cycle start: accept; o_remote_ack=1 next cycle; each valid cycle is a distinct packet (remote deasserts or advances data itself).
REQ-023 Accepted remote packet with lifetime 0 SHALL be acked and discarded, not written.
REQ-024 FIFO full: no accept, no ack; a simultaneous pop does not enable same-cycle accept.
REQ-025 Simultaneous push and pop on non-full FIFO SHALL both occur; occupancy unchanged.
REQ-026 FIFO pointers SHALL wrap modulo RFIFO_DEPTH; occupancy counter RFIFO_DEPTH+1 states.
REQ-027 Remote output SHALL depend only on source input, never on FIFO contents.

Reset
REQ-028 rst=0 SHALL asynchronously clear all output registers to 0, FIFO pointers/count to 0; o_node_empty=1.
REQ-029 Reset mid-operation SHALL discard FIFO contents and in-flight outputs; first valid outputs appear 1 cycle after the first post-reset edge with inputs.

Verification
REQ-030 Remote pkt id1 gcid 0 lt4, source idle -> ack next cycle; following cycle ring out id1 lt4 split0; o_node_empty 1->0->1.
REQ-031 Remote id2 lt0 -> ack pulse, no ring injection, FIFO unchanged.
REQ-032 Source id4 gcid 0x1FF lt8 split3, back_pressure=0, remote id3 lt3 same cycle -> ring id4 lt5 split0, remote id4 lt3 valid; id3 queued, ring next cycle when source lt0.
REQ-033 Same as REQ-032 with back_pressure=1 -> ring id4 lt8 split3, remote valid 0.
REQ-034 Source lt3 split3 with FIFO head queued -> remote id lt3, ring carries FIFO head same cycle.
REQ-035 Hold remote valid with source continuously valid -> exactly 4 acks, then no ack until FIFO drains; assert rst mid-stream -> all outputs 0, o_node_empty=1 immediately.
